issue_scoreboard: RTL and testbench

- Issue controller between the decoder and the execute resources (ALU, memory port, multi-cycle mul/div unit).
- Accepts one decoded instruction per cycle and tracks in-flight destination registers in a 32-entry scoreboard.
- Stalls the decoder on RAW/WAW hazards, on memory-port backpressure or outstanding-limit, and while mul/div is busy; routes each accepted instruction to exactly one unit.

---
 rtl/issue_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_issue_scoreboard.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
// Issue controller between the decoder and the execute resources (ALU, memory
// port, multi-cycle mul/div). It accepts one decoded instruction per cycle and
// tracks in-flight destination registers in a 32-entry scoreboard. The decoder
// is stalled on RAW/WAW hazards, on memory backpressure or outstanding limit,
// and while mul/div is busy.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   dec_valid/dec_ready decoder handshake (dec_ready is combinational)
//   rs1, rs2, rd        register fields; use_rs1/use_rs2/reg_write qualifiers
//   mem_access          2'b00 none, 2'b01 read, 2'b10 write
//   is_muldiv           instruction targets the mul/div unit
//   alu_issue           ALU issue pulse (combinational)
//   mem_issue/mem_ready memory request handshake; mem_done completion pulse
//   md_start/md_done    mul/div start and completion pulses
//   wb_valid/wb_rd      register writeback, clears the scoreboard entry
//   flush               suppresses issue this cycle
//   busy_vec            registered scoreboard, bit i = x<i> pending
//   stall_cycles        registered saturating stall-cycle counter
// -----------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int unsigned MEM_MAX_OUT = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             reg_write,
    input  logic [1:0]       mem_access,
    input  logic             is_muldiv,
    output logic             alu_issue,
    output logic             mem_issue,
    input  logic             mem_ready,
    input  logic             mem_done,
    output logic             md_start,
    input  logic             md_done,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [31:0]      busy_vec,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned   NREG          = 32;
    localparam int unsigned   MCNT_W        = 3;
    localparam logic [1:0]    MEM_NO_ACCESS = 2'b00;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    logic [NREG-1:0]   r_busy;
    logic [MCNT_W-1:0] r_mem_cnt;
    md_state_t         r_md_state;
    logic [CNT_W-1:0]  r_stall;

    logic [NREG-1:0]   w_wb_mask;
    logic [NREG-1:0]   w_eff;
    logic [NREG-1:0]   w_set_mask;
    logic              w_raw;
    logic              w_waw;
    logic              w_sel_mem;
    logic              w_sel_md;
    logic              w_sel_alu;
    logic              w_mem_room;
    logic              w_unit_ok;
    logic              w_clear;
    logic              w_fire;
    logic              w_mem_inc;
    logic              w_mem_dec;

    // Hazard detection against the scoreboard with same-cycle writeback bypass
    always_comb begin
        w_wb_mask = '0;
        if (wb_valid) begin
            w_wb_mask = NREG'(1) << wb_rd;
        end
        w_eff = r_busy & ~w_wb_mask;
        w_raw = (use_rs1 & w_eff[rs1]) | (use_rs2 & w_eff[rs2]);
        w_waw = reg_write & w_eff[rd];
    end

    // Unit selection: memory wins over mul/div, ALU is the fallback
    always_comb begin
        w_sel_mem  = (mem_access != MEM_NO_ACCESS);
        w_sel_md   = ~w_sel_mem & is_muldiv;
        w_sel_alu  = ~w_sel_mem & ~is_muldiv;
        w_mem_room = (r_mem_cnt < MCNT_W'(MEM_MAX_OUT));
        w_unit_ok  = w_sel_alu
                   | (w_sel_mem & mem_ready & w_mem_room)
                   | (w_sel_md & (r_md_state == MD_IDLE));
    end

    // Issue decision; gated by reset so all handshakes are low while in reset
    always_comb begin
        w_clear   = reset & dec_valid & ~flush & ~w_raw & ~w_waw;
        w_fire    = w_clear & w_unit_ok;
        dec_ready = w_fire;
        alu_issue = w_fire & w_sel_alu;
        md_start  = w_fire & w_sel_md;
        // Request is raised before mem_ready so the port can see it
        mem_issue = w_clear & w_sel_mem & w_mem_room;
    end

    // Next-state helpers for scoreboard and outstanding count
    always_comb begin
        w_set_mask = '0;
        if (w_fire && reg_write && (rd != 5'd0)) begin
            w_set_mask = NREG'(1) << rd;
        end
        w_mem_inc = mem_issue & mem_ready;
        w_mem_dec = mem_done & (r_mem_cnt != '0);
    end

    // Scoreboard: clear on writeback, then set on issue (set wins)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_wb_mask) | w_set_mask) & ~NREG'(1);
        end
    end

    // Outstanding memory operation count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_cnt <= '0;
        end else if (w_mem_inc && !w_mem_dec) begin
            r_mem_cnt <= r_mem_cnt + MCNT_W'(1);
        end else if (!w_mem_inc && w_mem_dec) begin
            r_mem_cnt <= r_mem_cnt - MCNT_W'(1);
        end
    end

    // Mul/div occupancy FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_state <= MD_IDLE;
        end else begin
            case (r_md_state)
                MD_IDLE: if (md_start) r_md_state <= MD_BUSY;
                MD_BUSY: if (md_done)  r_md_state <= MD_IDLE;
                default: r_md_state <= MD_IDLE;
            endcase
        end
    end

    // Saturating stall counter (flush cycles count as stalls)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (dec_valid && !w_fire && !(&r_stall)) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign busy_vec     = r_busy;
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

    localparam int unsigned MAXO = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid, dec_ready;
    logic [4:0]  rs1, rs2, rd, wb_rd;
    logic        use_rs1, use_rs2, reg_write, is_muldiv;
    logic [1:0]  mem_access;
    logic        alu_issue, mem_issue, mem_ready, mem_done;
    logic        md_start, md_done, wb_valid, flush;
    logic [31:0] busy_vec;
    logic [31:0] stall_cycles;

    issue_scoreboard #(.MEM_MAX_OUT(MAXO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .reg_write(reg_write),
        .mem_access(mem_access), .is_muldiv(is_muldiv),
        .alu_issue(alu_issue), .mem_issue(mem_issue), .mem_ready(mem_ready),
        .mem_done(mem_done), .md_start(md_start), .md_done(md_done),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_vec(busy_vec), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          mb[32];
    int          mcnt;
    bit          mmd;
    longint      mstall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = mb[i];
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) mb[i] = 1'b0;
        mcnt = 0; mmd = 1'b0; mstall = 0;
    endfunction

    // Expected combinational outputs from current inputs and model state
    function automatic void model_out(output bit e_fire, output bit e_alu,
                                      output bit e_mem, output bit e_md);
        bit eff[32];
        bit haz, go, room, ok;
        int unit;
        for (int i = 0; i < 32; i++) eff[i] = mb[i] && !(wb_valid && int'(wb_rd) == i);
        haz  = (use_rs1 && eff[rs1]) || (use_rs2 && eff[rs2]) || (reg_write && eff[rd]);
        unit = (mem_access != 2'b00) ? 1 : (is_muldiv ? 2 : 0);
        room = (mcnt < int'(MAXO));
        go   = reset && dec_valid && !flush && !haz;
        ok   = (unit == 0) ? 1'b1 : (unit == 1) ? (mem_ready && room) : !mmd;
        e_fire = go && ok;
        e_alu  = e_fire && unit == 0;
        e_md   = e_fire && unit == 2;
        e_mem  = go && unit == 1 && room;
    endfunction

    // One clock: compare all outputs against the model, then advance the model
    task automatic step();
        bit f, a, m, d, inc;
        #1;
        model_out(f, a, m, d);
        chk("dec_ready", dec_ready, f);
        chk("alu_issue", alu_issue, a);
        chk("mem_issue", mem_issue, m);
        chk("md_start", md_start, d);
        chk("busy_vec", busy_vec, model_busy());
        chk("stall_cycles", stall_cycles, mstall);
        @(posedge clk);
        if (dec_valid && !f && mstall < 64'hFFFF_FFFF) mstall++;
        if (wb_valid) mb[wb_rd] = 1'b0;
        if (f && reg_write && rd != 0) mb[rd] = 1'b1;
        inc = m && mem_ready;
        if (inc && mem_done && mcnt > 0) mcnt = mcnt;
        else if (inc) mcnt++;
        else if (mem_done && mcnt > 0) mcnt--;
        if (mmd && md_done) mmd = 1'b0;
        else if (d) mmd = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_in();
        dec_valid = 0; rs1 = 0; rs2 = 0; rd = 0; use_rs1 = 0; use_rs2 = 0;
        reg_write = 0; mem_access = 0; is_muldiv = 0; mem_ready = 0;
        mem_done = 0; md_done = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic instr(input logic [4:0] d, input logic [1:0] ma, input logic md);
        dec_valid = 1; rd = d; reg_write = (d != 0); mem_access = ma; is_muldiv = md;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_stall", stall_cycles, 32'h0);
        chk("rst_ready", dec_ready, 1'b0);
        @(negedge clk);
        reset = 1;
        model_clear();
        idle_in();
    endtask

    initial begin
        idle_in();
        model_clear();
        reset = 0;
        dec_valid = 1;  // outputs must stay low in reset regardless
        #2;
        chk("init_ready", dec_ready, 1'b0);
        chk("init_alu", alu_issue, 1'b0);
        chk("init_busy", busy_vec, 32'h0);
        chk("init_stall", stall_cycles, 32'h0);
        @(negedge clk);
        reset = 1;
        idle_in();

        // ALU back-to-back RAW with bypass
        instr(5, 2'b00, 0); step();
        chk("alu_busy20", busy_vec, 32'h20);
        idle_in(); dec_valid = 1; use_rs1 = 1; rs1 = 5;
        #1 chk("raw_stall_ready", dec_ready, 1'b0);
        step();
        chk("raw_stall_cnt", stall_cycles, 32'd1);
        instr(5, 2'b00, 0); use_rs1 = 1; rs1 = 5; wb_valid = 1; wb_rd = 5;
        #1 chk("bypass_fire", dec_ready, 1'b1);
        step();
        chk("reset_bit5", busy_vec, 32'h20);

        // x0 never becomes busy
        idle_in(); wb_valid = 1; wb_rd = 5; step();
        idle_in(); dec_valid = 1; reg_write = 1; rd = 0;
        for (int i = 0; i < 4; i++) step();
        chk("x0_busy", busy_vec, 32'h0);
        chk("x0_stall", stall_cycles, 32'd1);

        // Memory outstanding limit
        do_reset();
        mem_ready = 1;
        instr(6, 2'b01, 0); step();
        instr(7, 2'b01, 0); step();
        instr(8, 2'b01, 0);
        #1 chk("mem_lim_issue", mem_issue, 1'b0);
        chk("mem_lim_ready", dec_ready, 1'b0);
        step();
        mem_done = 1; step();
        mem_done = 0;
        #1 chk("mem_after_done", mem_issue, 1'b1);
        step();
        mem_done = 1; step();                 // count 2 -> 1
        mem_done = 1; instr(9, 2'b10, 0); step();   // simultaneous: stays 1
        mem_done = 0; instr(10, 2'b01, 0);
        #1 chk("mem_simul_room", dec_ready, 1'b1);
        step();
        instr(11, 2'b01, 0);
        #1 chk("mem_full_again", mem_issue, 1'b0);
        step();
        chk("mem_busy", busy_vec, 32'h7C0);

        // Memory backpressure
        do_reset();
        instr(12, 2'b01, 0); mem_ready = 0;
        #1 chk("bp_issue", mem_issue, 1'b1);
        chk("bp_ready", dec_ready, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("bp_stall", stall_cycles, 32'd3);
        chk("bp_busy", busy_vec, 32'h0);
        mem_ready = 1; step();
        chk("bp_busy_set", busy_vec, 32'h1000);

        // Mul/div occupancy and WAW
        do_reset();
        instr(10, 2'b00, 1);
        #1 chk("md_start1", md_start, 1'b1);
        step();
        instr(11, 2'b00, 1);
        #1 chk("md_blocked", dec_ready, 1'b0);
        step(); step();
        md_done = 1;
        #1 chk("md_done_cycle", md_start, 1'b0);
        step();
        md_done = 0;
        #1 chk("md_start2", md_start, 1'b1);
        step();
        chk("md_busy", busy_vec, 32'hC00);
        instr(10, 2'b00, 0); is_muldiv = 0;
        #1 chk("waw_block", dec_ready, 1'b0);
        step();
        wb_valid = 1; wb_rd = 10;
        #1 chk("waw_bypass", alu_issue, 1'b1);
        step();

        // Async reset mid-operation
        do_reset();
        instr(10, 2'b00, 1); step();
        instr(0, 2'b10, 0); mem_ready = 1; step();
        chk("pre_rst_busy", busy_vec, 32'h400);
        instr(1, 2'b00, 0);
        #2 reset = 0;
        #1;
        chk("async_ready", dec_ready, 1'b0);
        chk("async_alu", alu_issue, 1'b0);
        chk("async_busy", busy_vec, 32'h0);
        @(negedge clk);
        reset = 1; model_clear(); idle_in();
        instr(11, 2'b00, 1);
        #1 chk("post_rst_md", md_start, 1'b1);
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(999) == 0) do_reset();
            dec_valid  = ($urandom_range(3) != 0);
            rs1        = 5'($urandom_range(7));
            rs2        = 5'($urandom_range(7));
            rd         = 5'($urandom_range(7));
            use_rs1    = 1'($urandom);
            use_rs2    = 1'($urandom);
            reg_write  = 1'($urandom);
            mem_access = 2'($urandom_range(3));
            if ($urandom_range(1) == 0) mem_access = 2'b00;
            is_muldiv  = ($urandom_range(3) == 0);
            mem_ready  = ($urandom_range(3) != 0);
            mem_done   = ($urandom_range(3) == 0);
            md_done    = ($urandom_range(4) == 0);
            wb_valid   = ($urandom_range(2) == 0);
            wb_rd      = 5'($urandom_range(7));
            flush      = ($urandom_range(9) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
